// File: rtl/instruction_store.sv
// instruction_store
// Writable instruction memory placed in front of the fetch stage. Fetches are
// registered with one cycle of latency. A byte-serial load port assembles
// bytes (most significant first) into words and writes them at consecutive
// addresses starting from a captured base.
//
// Ports
//   Clock, Reset          : clock, asynchronous active-high reset
//   iAddress, iFetch      : fetch request (ignored while a load is busy)
//   oInstruction, oValid  : registered fetch data and its one-cycle strobe
//   iLoadStart, iLoadBase : begin a load at the given base address
//   iLoadByte, iLoadByteValid, iLoadLast : byte stream, last-byte marker
//   oLoadReady            : a byte is accepted this cycle
//   oLoadBusy             : load in progress (LOAD or WRITE)
//   oLoadDone             : one-cycle pulse at load completion
//   oLoadError            : sticky flag, a word addressed >= DEPTH was dropped
module instruction_store #(
  parameter int                    DATA_WIDTH   = 28,
  parameter int                    DEPTH        = 256,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = {DATA_WIDTH{1'b0}},
  parameter string                 INIT_FILE    = ""
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [15:0]           iAddress,
  input  logic                  iFetch,
  output logic [DATA_WIDTH-1:0] oInstruction,
  output logic                  oValid,
  input  logic                  iLoadStart,
  input  logic [15:0]           iLoadBase,
  input  logic [7:0]            iLoadByte,
  input  logic                  iLoadByteValid,
  input  logic                  iLoadLast,
  output logic                  oLoadReady,
  output logic                  oLoadBusy,
  output logic                  oLoadDone,
  output logic                  oLoadError
);

  localparam int BYTES = (DATA_WIDTH + 7) / 8;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] BYTES_C = CNT_W'(BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [15:0]             wptr_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [DATA_WIDTH-1:0]   asm_r;
  logic                    last_r;
  logic                    err_r;
  logic                    ready_r;
  logic                    busy_r;
  logic                    done_r;
  logic [DATA_WIDTH-1:0]   instr_r;
  logic                    valid_r;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

  logic                    byte_take_s;
  logic                    fetch_hit_s;
  logic                    wptr_ok_s;

  // Address range decodes and byte acceptance.
  always_comb begin
    byte_take_s = (state_r == LOAD) && iLoadByteValid;
    fetch_hit_s = ({1'b0, iAddress} < 17'(DEPTH));
    wptr_ok_s   = ({1'b0, wptr_r} < 17'(DEPTH));
  end

  // Load FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (iLoadStart) state_s = LOAD;
        else            state_s = IDLE;
      end
      LOAD: begin
        if (byte_take_s && ((cnt_r + 3'd1 == BYTES_C) || iLoadLast)) state_s = WRITE;
        else                                                          state_s = LOAD;
      end
      WRITE: begin
        if (last_r) state_s = DONE;
        else        state_s = LOAD;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM state, write pointer, byte assembly and sticky error.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
      wptr_r  <= 16'd0;
      cnt_r   <= 3'd0;
      asm_r   <= {DATA_WIDTH{1'b0}};
      last_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (iLoadStart) begin
            wptr_r <= iLoadBase;
            cnt_r  <= 3'd0;
            asm_r  <= {DATA_WIDTH{1'b0}};
            last_r <= 1'b0;
            err_r  <= 1'b0;
          end
        end
        LOAD: begin
          if (byte_take_s) begin
            // Byte k of a word lands in lane BYTES-1-k, so a short final
            // word stays left-aligned with zero low lanes (asm_r was cleared).
            for (int i = 0; i < DATA_WIDTH; i++) begin
              if (cnt_r == CNT_W'(BYTES - 1 - i / 8)) asm_r[i] <= iLoadByte[i % 8];
            end
            cnt_r  <= cnt_r + 3'd1;
            last_r <= iLoadLast;
          end
        end
        WRITE: begin
          if (!wptr_ok_s) err_r <= 1'b1;
          wptr_r <= wptr_r + 16'd1;
          cnt_r  <= 3'd0;
          asm_r  <= {DATA_WIDTH{1'b0}};
        end
        DONE:    last_r <= 1'b0;
        default: last_r <= 1'b0;
      endcase
    end
  end

  // Status outputs registered from the next state so they align with it.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      ready_r <= (state_s == LOAD);
      busy_r  <= (state_s == LOAD) || (state_s == WRITE);
      done_r  <= (state_s == DONE);
    end
  end

  // Memory write port; contents deliberately survive reset.
  always_ff @(posedge Clock) begin
    if ((state_r == WRITE) && wptr_ok_s) mem_r[wptr_r[AW-1:0]] <= asm_r;
  end

  // Registered fetch path, blocked while a load is busy.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      instr_r <= DEFAULT_WORD;
      valid_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (iFetch && !busy_r) begin
        valid_r <= 1'b1;
        if (fetch_hit_s) instr_r <= mem_r[iAddress[AW-1:0]];
        else             instr_r <= DEFAULT_WORD;
      end
    end
  end

  assign oInstruction = instr_r;
  assign oValid       = valid_r;
  assign oLoadReady   = ready_r;
  assign oLoadBusy    = busy_r;
  assign oLoadDone    = done_r;
  assign oLoadError   = err_r;

endmodule

// File: tb/tb_instruction_store.sv
// Directed bench for instruction_store (default parameters).
module tb_instruction_store;

  logic        Clock;
  logic        Reset;
  logic [15:0] iAddress;
  logic        iFetch;
  logic [27:0] oInstruction;
  logic        oValid;
  logic        iLoadStart;
  logic [15:0] iLoadBase;
  logic [7:0]  iLoadByte;
  logic        iLoadByteValid;
  logic        iLoadLast;
  logic        oLoadReady;
  logic        oLoadBusy;
  logic        oLoadDone;
  logic        oLoadError;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int nwr      = 0;
  int ndone    = 0;
  int wr_cyc [8];

  instruction_store dut (
    .Clock(Clock), .Reset(Reset),
    .iAddress(iAddress), .iFetch(iFetch),
    .oInstruction(oInstruction), .oValid(oValid),
    .iLoadStart(iLoadStart), .iLoadBase(iLoadBase),
    .iLoadByte(iLoadByte), .iLoadByteValid(iLoadByteValid), .iLoadLast(iLoadLast),
    .oLoadReady(oLoadReady), .oLoadBusy(oLoadBusy),
    .oLoadDone(oLoadDone), .oLoadError(oLoadError)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Cycle counter.
  always @(posedge Clock) cyc <= cyc + 1;

  // Record cycles spent in WRITE (busy, not ready) and done pulses.
  always @(negedge Clock) begin
    if (!Reset && oLoadBusy && !oLoadReady) begin
      if (nwr < 8) wr_cyc[nwr] <= cyc;
      nwr <= nwr + 1;
    end
    if (!Reset && oLoadDone) ndone <= ndone + 1;
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_load(input logic [15:0] base);
    iLoadStart = 1'b1;
    iLoadBase  = base;
    step();
    iLoadStart = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int g = 0;
    iLoadByteValid = 1'b0;
    while (oLoadReady !== 1'b1 && g < 50) begin
      step();
      g++;
    end
    chk("ready_wait", {31'd0, (g < 50)}, 32'd1);
    iLoadByte      = b;
    iLoadLast      = last;
    iLoadByteValid = 1'b1;
    step();
    iLoadByteValid = 1'b0;
    iLoadLast      = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    for (int b = 3; b >= 0; b--) send_byte(w[b*8 +: 8], last && (b == 0));
  endtask

  task automatic wait_done(input string tag);
    int g = 0;
    while (oLoadDone !== 1'b1 && g < 20) begin
      step();
      g++;
    end
    chk(tag, {31'd0, oLoadDone}, 32'd1);
    chk({tag, "_busy"}, {31'd0, oLoadBusy}, 32'd0);
  endtask

  task automatic fetch(input logic [15:0] addr);
    iFetch   = 1'b1;
    iAddress = addr;
    step();
    iFetch   = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; iAddress = 16'd0; iFetch = 1'b0; iLoadStart = 1'b0;
    iLoadBase = 16'd0; iLoadByte = 8'd0; iLoadByteValid = 1'b0; iLoadLast = 1'b0;
    #12;
    chk("rst_instr", {4'd0, oInstruction}, 32'h0);
    chk("rst_valid", {31'd0, oValid}, 32'd0);
    chk("rst_ready", {31'd0, oLoadReady}, 32'd0);
    chk("rst_busy",  {31'd0, oLoadBusy}, 32'd0);
    chk("rst_done",  {31'd0, oLoadDone}, 32'd0);
    chk("rst_err",   {31'd0, oLoadError}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    step();

    // Three words at base 5, continuous stream.
    start_load(16'd5);
    chk("start_ready", {31'd0, oLoadReady}, 32'd1);
    chk("start_busy",  {31'd0, oLoadBusy}, 32'd1);
    send_word(32'h01234567, 1'b0);
    send_word(32'h0ABCDEF0, 1'b0);
    send_word(32'h00000001, 1'b1);
    wait_done("load1_done");
    chk("load1_err", {31'd0, oLoadError}, 32'd0);
    step();
    chk("load1_nwr",  nwr, 32'd3);
    chk("wr_gap01",   wr_cyc[1] - wr_cyc[0], 32'd5);
    chk("wr_gap12",   wr_cyc[2] - wr_cyc[1], 32'd5);
    chk("done_once",  ndone, 32'd1);

    // Back-to-back fetches at 5, 6, 7.
    iFetch = 1'b1; iAddress = 16'd5;
    step();
    chk("f5_valid", {31'd0, oValid}, 32'd1);
    chk("f5_data",  {4'd0, oInstruction}, 32'h1234567);
    iAddress = 16'd6;
    step();
    chk("f6_data",  {4'd0, oInstruction}, 32'hABCDEF0);
    iAddress = 16'd7;
    step();
    chk("f7_data",  {4'd0, oInstruction}, 32'h0000001);
    chk("f7_valid", {31'd0, oValid}, 32'd1);
    iFetch = 1'b0;
    step();
    chk("idle_valid", {31'd0, oValid}, 32'd0);
    chk("idle_hold",  {4'd0, oInstruction}, 32'h0000001);

    // Partial word at base 10; fetch and restart while busy are ignored.
    start_load(16'd10);
    iFetch = 1'b1; iAddress = 16'd5;
    iLoadStart = 1'b1; iLoadBase = 16'd200;
    step();
    iFetch = 1'b0; iLoadStart = 1'b0;
    chk("busy_novalid", {31'd0, oValid}, 32'd0);
    chk("busy_hold",    {4'd0, oInstruction}, 32'h0000001);
    send_byte(8'h0A, 1'b0);
    send_byte(8'hBC, 1'b1);
    wait_done("part_done");
    chk("part_err", {31'd0, oLoadError}, 32'd0);
    fetch(16'd10);
    chk("part_data", {4'd0, oInstruction}, 32'hABC0000);

    // Out-of-range fetch.
    fetch(16'd300);
    chk("oor_valid", {31'd0, oValid}, 32'd1);
    chk("oor_data",  {4'd0, oInstruction}, 32'h0);

    // Byte held valid through WRITE is dropped.
    start_load(16'd20);
    iLoadByteValid = 1'b1;
    iLoadByte = 8'h11; step();
    iLoadByte = 8'h22; step();
    iLoadByte = 8'h33; step();
    iLoadByte = 8'h44; step();
    chk("wr_ready_low", {31'd0, oLoadReady}, 32'd0);
    iLoadByte = 8'hEE; step();
    iLoadByte = 8'h05; step();
    iLoadByte = 8'h06; iLoadLast = 1'b1; step();
    iLoadByteValid = 1'b0; iLoadLast = 1'b0;
    wait_done("drop_done");
    fetch(16'd20);
    chk("drop_w0", {4'd0, oInstruction}, 32'h1223344);
    fetch(16'd21);
    chk("drop_w1", {4'd0, oInstruction}, 32'h5060000);

    // Overflow past the last address.
    start_load(16'd255);
    send_word(32'h07654321, 1'b0);
    send_word(32'h01111111, 1'b1);
    wait_done("ovf_done");
    chk("ovf_err", {31'd0, oLoadError}, 32'd1);
    step(); step(); step();
    chk("ovf_err_sticky", {31'd0, oLoadError}, 32'd1);
    fetch(16'd255);
    chk("ovf_w255", {4'd0, oInstruction}, 32'h7654321);

    // New start clears the error; reset mid-word.
    start_load(16'd30);
    chk("err_cleared", {31'd0, oLoadError}, 32'd0);
    send_byte(8'h0A, 1'b0);
    send_byte(8'hBB, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_instr", {4'd0, oInstruction}, 32'h0);
    chk("arst_ready", {31'd0, oLoadReady}, 32'd0);
    chk("arst_busy",  {31'd0, oLoadBusy}, 32'd0);
    chk("arst_valid", {31'd0, oValid}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    step();
    fetch(16'd5);
    chk("persist_w5", {4'd0, oInstruction}, 32'h1234567);
    fetch(16'd255);
    chk("persist_w255", {4'd0, oInstruction}, 32'h7654321);

    // Fresh load after reset.
    start_load(16'd40);
    send_word(32'h0BEEF12, 1'b1);
    wait_done("post_rst_done");
    fetch(16'd40);
    chk("post_rst_w40", {4'd0, oInstruction}, 32'h0BEEF12);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
